arbitro_mem_dados: RTL
======================

// Module: arbitro_mem_dados
// PURPOSE
//   Arbitrates the single-port data RAM between the 8-bit processor core and a host/debug port.
//   The host port is used for loading vectors before a run, inspecting results after HLT, and
//   live peeking during a run. The CPU owns the RAM by default. A granted host access freezes
//   the core for one cycle through cpu_stall. A wait counter bounds host starvation.
// PARAMETERS
//   MAX_WAIT  4   max counted CPU-contended cycles a pending host_req waits (0 = host wins next cycle)
//   CNT_W     16  width of stall_cycles performance counter
// PORTS
//   clk          in   1      clock; all state updates on posedge
//   reset        in   1      synchronous, active-high reset
//   cpu_memR     in   1      core data-memory read enable
//   cpu_memW     in   1      core data-memory write enable
//   cpu_addr     in   8      core address (ALU output)
//   cpu_wdata    in   8      core write data
//   cpu_hlt      in   1      core is executing HLT (no further memory use)
//   cpu_rdata    out  8      read data to core (= ram_dout, combinational)
//   cpu_stall    out  1      core must hold PC and suppress all register/memory writes this cycle
//   host_req     in   1      host request; host_we/host_addr/host_wdata held stable until host_ack
//   host_we      in   1      1 = write, 0 = read
//   host_addr    in   8      host address
//   host_wdata   in   8      host write data
//   host_ack     out  1      one-cycle completion pulse
//   host_rdata   out  8      read data; valid while host_ack=1, held afterwards
//   ram_addr     out  8      RAM address
//   ram_re       out  1      RAM read enable
//   ram_we       out  1      RAM write enable (written at posedge)
//   ram_din      out  8      RAM write data
//   ram_dout     in   8      RAM read data (combinational read)
//   stall_cycles out  CNT_W  count of cycles with cpu_stall=1; saturates at all-ones
// BEHAVIOUR
//   States: S_CPU, S_HOST, S_ACK. Reset (sync) -> S_CPU, wait_cnt=0, host_ack=0, host_rdata=0,
//     stall_cycles=0. cpu_stall=0 and RAM muxed to CPU on the first cycle after reset.
//   cpu_acc = cpu_memR | cpu_memW.
//   S_CPU: RAM driven by CPU (ram_addr=cpu_addr, ram_re=cpu_memR, ram_we=cpu_memW, ram_din=cpu_wdata).
//     cpu_stall=0. CPU access in this cycle always completes.
//     go = host_req & (cpu_hlt | ~cpu_acc | wait_cnt==MAX_WAIT); go -> S_HOST, wait_cnt<=0.
//     Else if host_req & cpu_acc & ~cpu_hlt: wait_cnt++ (saturating at MAX_WAIT).
//     Else if ~host_req: wait_cnt<=0.
//   S_HOST: RAM driven by host (ram_re=~host_we, ram_we=host_we). cpu_stall=1. stall_cycles++.
//     If ~host_we, host_rdata <= ram_dout. Unconditional -> S_ACK.
//   S_ACK: host_ack=1. RAM driven by CPU; cpu_stall=0. host_req is ignored this cycle (the host
//     drops it on ack). -> S_CPU.
//   Latency: host_req first high in cycle N with go=1 -> access in N+1, host_ack in N+2.
//     Host throughput is at most 1 access per 3 cycles. The CPU loses at most 1 cycle per host access.
//   host_req dropped before ack: an already-entered S_HOST still completes and acks.
//     In S_CPU, a dropped request clears wait_cnt.
//   Reset asserted during S_HOST: that cycle's host RAM write still lands at the edge.
//     The state returns to S_CPU and no host_ack is issued.
//   cpu_rdata always = ram_dout. It is meaningful only when cpu_stall=0.
//   host_ack and host_rdata are registered. All other outputs are combinational from state and inputs.
// TESTING
//   Reset held 2 cycles mid-run -> cpu_stall=0, host_ack=0, host_rdata=0, stall_cycles=0,
//     ram_* follow the CPU inputs.
//   CPU idle; host_req=1, we=1, addr=0x10, wdata=0x5A at cycle 0 -> cycle 1 ram_we=1,
//     ram_addr=0x10, ram_din=0x5A, cpu_stall=1; cycle 2 host_ack=1; stall_cycles=1; RAM[0x10]=0x5A.
//   RAM[0x03]=7, CPU idle, host read addr 0x03 -> cycle 2 host_ack=1, host_rdata=7; host_rdata stays 7 after ack.
//   MAX_WAIT=4, cpu_memR=1 every cycle, host read from cycle 0 -> cycles 0-3 counted, grant decided in
//     cycle 4, S_HOST in cycle 5 (cpu_stall=1 only then), ack in cycle 6; the CPU sees no other stall.
//   cpu_hlt=1 with cpu_memW stuck at 1, host_req at cycle 0 -> S_HOST in cycle 1 (no waiting).
//     50 back-to-back host reads return RAM contents; stall_cycles=50.
//   Reset asserted in the S_HOST cycle of a host write to 0x20 -> RAM[0x20] updated,
//     host_ack never pulses, next cycle in S_CPU.

Source files
------------

// File: rtl/arbitro_mem_dados.sv
// Data-RAM arbiter between the 8-bit core and the host/debug port.
// The core owns the RAM by default; a host access steals exactly one cycle and stalls the core.
module arbitro_mem_dados #(
   parameter int MAX_WAIT = 4,
   parameter int CNT_W    = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cpu_memR,
   input  logic             cpu_memW,
   input  logic [7:0]       cpu_addr,
   input  logic [7:0]       cpu_wdata,
   input  logic             cpu_hlt,
   output logic [7:0]       cpu_rdata,
   output logic             cpu_stall,
   input  logic             host_req,
   input  logic             host_we,
   input  logic [7:0]       host_addr,
   input  logic [7:0]       host_wdata,
   output logic             host_ack,
   output logic [7:0]       host_rdata,
   output logic [7:0]       ram_addr,
   output logic             ram_re,
   output logic             ram_we,
   output logic [7:0]       ram_din,
   input  logic [7:0]       ram_dout,
   output logic [CNT_W-1:0] stall_cycles
);

   localparam int WAIT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
   localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'(MAX_WAIT);

   localparam logic [1:0] S_CPU  = 2'd0;
   localparam logic [1:0] S_HOST = 2'd1;
   localparam logic [1:0] S_ACK  = 2'd2;

   logic [1:0]        state;
   logic [1:0]        state_next;
   logic [WAIT_W-1:0] wait_cnt;
   logic              cpu_acc;
   logic              go;
   logic              host_cycle;

   // A halted or idle core never makes the host wait; a busy core only delays it MAX_WAIT cycles.
   assign cpu_acc    = cpu_memR | cpu_memW;
   assign go         = (state == S_CPU) & host_req &
                       (cpu_hlt | ~cpu_acc | (wait_cnt == WAIT_LIM));
   assign host_cycle = (state == S_HOST);

   always_comb begin
      state_next = state;
      case (state)
         S_CPU:   if (go) state_next = S_HOST;
         S_HOST:  state_next = S_ACK;
         S_ACK:   state_next = S_CPU;
         default: state_next = S_CPU;
      endcase
   end

   assign ram_addr  = host_cycle ? host_addr  : cpu_addr;
   assign ram_din   = host_cycle ? host_wdata : cpu_wdata;
   assign ram_re    = host_cycle ? ~host_we   : cpu_memR;
   assign ram_we    = host_cycle ? host_we    : cpu_memW;
   assign cpu_stall = host_cycle;
   assign cpu_rdata = ram_dout;

   // The host-cycle RAM write is combinational, so it still lands even if reset hits that edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= S_CPU;
         wait_cnt     <= '0;
         host_ack     <= 1'b0;
         host_rdata   <= '0;
         stall_cycles <= '0;
      end else begin
         state    <= state_next;
         host_ack <= host_cycle;
         if (host_cycle && !host_we)
            host_rdata <= ram_dout;
         if (host_cycle && (stall_cycles != '1))
            stall_cycles <= stall_cycles + CNT_W'(1);
         if (state == S_CPU) begin
            if (go)
               wait_cnt <= '0;
            else if (host_req && cpu_acc && !cpu_hlt) begin
               if (wait_cnt != WAIT_LIM)
                  wait_cnt <= wait_cnt + WAIT_W'(1);
            end else if (!host_req)
               wait_cnt <= '0;
         end
      end
   end

endmodule
